// File: rtl/crop_video_cfg_bank_pkg.sv
// rtl/crop_video_cfg_bank_pkg.sv - shared types and constants for the crop window config bank
//
// Purpose:
//   Window struct, config opcode and bank FSM state enums, default geometry and
//   a helper that builds the power-on default window {x=0,y=0,w=max_w,h=max_h}.
//   The window struct is packed {h,w,y,x} so that it matches the act_win lane
//   layout directly.
package crop_video_cfg_bank_pkg;

  localparam int CROP_COORD_W = 12;
  localparam int CROP_MAX_W   = 1920;
  localparam int CROP_MAX_H   = 1080;

  typedef struct packed {
    logic [CROP_COORD_W-1:0] h;
    logic [CROP_COORD_W-1:0] w;
    logic [CROP_COORD_W-1:0] y;
    logic [CROP_COORD_W-1:0] x;
  } crop_win_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_ARM   = 1'b1
  } cfg_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bank_state_e;

  function automatic crop_win_t default_win(input int max_w, input int max_h);
    crop_win_t v;
    v.x = '0;
    v.y = '0;
    v.w = CROP_COORD_W'(max_w);
    v.h = CROP_COORD_W'(max_h);
    return v;
  endfunction

  localparam crop_win_t CROP_DEFAULT_WIN = default_win(CROP_MAX_W, CROP_MAX_H);

endpackage

// File: rtl/crop_video_cfg_check.sv
// rtl/crop_video_cfg_check.sv - combinational bounds checker for one crop window write
//
// Purpose:
//   Accepts a window only if w and h are non-zero, x+w <= MAX_W, y+h <= MAX_H
//   and the channel index exists. Sums are one bit wider than a coordinate so
//   large x/w values can never wrap back into range.
// Ports:
//   i_win  in   4*CROP_COORD_W  packed window {h,w,y,x}
//   i_ch   in   CH_W            target channel
//   o_ok   out  1               1 = write may be committed
module crop_video_cfg_check
  import crop_video_cfg_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MAX_W  = CROP_MAX_W,
  parameter int MAX_H  = CROP_MAX_H,
  parameter int CH_W   = 2
) (
  input  logic [4*CROP_COORD_W-1:0] i_win,
  input  logic [CH_W-1:0]           i_ch,
  output logic                      o_ok
);

  localparam int SUM_W = CROP_COORD_W + 1;
  localparam logic [SUM_W-1:0] LP_MAX_W  = SUM_W'(MAX_W);
  localparam logic [SUM_W-1:0] LP_MAX_H  = SUM_W'(MAX_H);
  localparam logic [CH_W:0]    LP_NUM_CH = (CH_W+1)'(NUM_CH);

  crop_win_t        w_win;
  logic [SUM_W-1:0] w_x_end;
  logic [SUM_W-1:0] w_y_end;
  logic             w_size_ok;
  logic             w_x_ok;
  logic             w_y_ok;
  logic             w_ch_ok;

  assign w_win     = crop_win_t'(i_win);
  assign w_x_end   = {1'b0, w_win.x} + {1'b0, w_win.w};
  assign w_y_end   = {1'b0, w_win.y} + {1'b0, w_win.h};
  assign w_size_ok = (w_win.w != '0) && (w_win.h != '0);
  assign w_x_ok    = (w_x_end <= LP_MAX_W);
  assign w_y_ok    = (w_y_end <= LP_MAX_H);
  assign w_ch_ok   = ({1'b0, i_ch} < LP_NUM_CH);
  assign o_ok      = w_size_ok && w_x_ok && w_y_ok && w_ch_ok;

endmodule

// File: rtl/crop_video_cfg_bank.sv
// rtl/crop_video_cfg_bank.sv - multi-channel crop window bank with frame-aligned apply
//
// Purpose:
//   Config requests (WRITE shadow / ARM channel) enter through a valid/ready
//   port, sit one cycle in stage S1 where they are bounds-checked, and commit
//   on the edge that ends S1. An armed channel copies shadow to active on its
//   next start-of-frame, so active windows only change between frames.
//   After reset an INIT phase loads the default window into one channel per
//   cycle; requests are refused until it completes.
//   COORD_W must equal CROP_COORD_W from the package (the window struct width).
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_cfg_valid/o_cfg_ready request handshake (ready only in RUN)
//   i_cfg_op               0 = WRITE shadow, 1 = ARM channel
//   i_cfg_ch               target channel
//   i_cfg_x/y/w/h          window for WRITE
//   i_sof                  per-channel start-of-frame pulse
//   o_act_win              active windows, ch0 in LSBs, {h,w,y,x} per channel
//   o_applied              per-channel 1-cycle pulse: shadow copied to active
//   o_cfg_err              1-cycle pulse: request rejected
//   o_init_done            high once defaults are loaded
module crop_video_cfg_bank
  import crop_video_cfg_bank_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int COORD_W = CROP_COORD_W,
  parameter int MAX_W   = CROP_MAX_W,
  parameter int MAX_H   = CROP_MAX_H,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic                      i_cfg_op,
  input  logic [CH_W-1:0]           i_cfg_ch,
  input  logic [COORD_W-1:0]        i_cfg_x,
  input  logic [COORD_W-1:0]        i_cfg_y,
  input  logic [COORD_W-1:0]        i_cfg_w,
  input  logic [COORD_W-1:0]        i_cfg_h,
  input  logic [NUM_CH-1:0]         i_sof,
  output logic [NUM_CH*4*COORD_W-1:0] o_act_win,
  output logic [NUM_CH-1:0]         o_applied,
  output logic                      o_cfg_err,
  output logic                      o_init_done
);

  localparam int               WIN_W   = 4 * COORD_W;
  localparam crop_win_t        DEF_WIN = default_win(MAX_W, MAX_H);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]    LP_NUM_CH = (CH_W+1)'(NUM_CH);

  // FSM
  bank_state_e     r_state;
  bank_state_e     w_state_nxt;
  logic [CH_W-1:0] r_init_cnt;
  logic [CH_W-1:0] w_init_cnt_nxt;
  logic            r_init_done;
  logic            w_cfg_ready;
  logic            w_init_phase;
  logic            w_accept;

  // S1 request stage
  logic            r_s1_vld;
  cfg_op_e         r_s1_op;
  logic [CH_W-1:0] r_s1_ch;
  crop_win_t       r_s1_win;
  logic            w_chk_ok;
  logic            w_arm_ch_ok;
  logic            w_s1_wr;
  logic            w_s1_arm;
  logic            w_s1_err;
  logic            r_cfg_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_cfg_ready    = 1'b0;
    w_init_phase   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_phase = 1'b1;
        if (r_init_cnt == LAST_CH) begin
          w_state_nxt    = ST_RUN;
          w_init_cnt_nxt = '0;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_cfg_ready = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign w_accept = i_cfg_valid && w_cfg_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_op  <= OP_WRITE;
      r_s1_ch  <= '0;
      r_s1_win <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_op    <= cfg_op_e'(i_cfg_op);
        r_s1_ch    <= i_cfg_ch;
        r_s1_win.x <= i_cfg_x;
        r_s1_win.y <= i_cfg_y;
        r_s1_win.w <= i_cfg_w;
        r_s1_win.h <= i_cfg_h;
      end
    end
  end

  crop_video_cfg_check #(
    .NUM_CH (NUM_CH),
    .MAX_W  (MAX_W),
    .MAX_H  (MAX_H),
    .CH_W   (CH_W)
  ) u_check (
    .i_win (r_s1_win),
    .i_ch  (r_s1_ch),
    .o_ok  (w_chk_ok)
  );

  // ARM needs only a valid channel; the window fields are don't-care.
  assign w_arm_ch_ok = ({1'b0, r_s1_ch} < LP_NUM_CH);
  assign w_s1_wr     = r_s1_vld && (r_s1_op == OP_WRITE) && w_chk_ok;
  assign w_s1_arm    = r_s1_vld && (r_s1_op == OP_ARM) && w_arm_ch_ok;
  assign w_s1_err    = r_s1_vld && ((r_s1_op == OP_WRITE) ? !w_chk_ok : !w_arm_ch_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_s1_err;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    crop_win_t r_shadow;
    crop_win_t r_active;
    logic      r_armed;
    logic      r_applied;
    logic      w_hit;
    logic      w_init_ld;
    logic      w_apply;

    assign w_hit     = (r_s1_ch == CH_W'(i));
    assign w_init_ld = w_init_phase && (r_init_cnt == CH_W'(i));
    assign w_apply   = (r_state == ST_RUN) && i_sof[i] && r_armed;

    // Apply reads the pre-edge shadow and armed flag, so an S1 commit landing
    // on the same edge as sof only affects the following frame. A same-edge
    // ARM is written after the apply clear and therefore survives.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_shadow  <= '0;
        r_active  <= '0;
        r_armed   <= 1'b0;
        r_applied <= 1'b0;
      end else if (w_init_ld) begin
        r_shadow  <= DEF_WIN;
        r_active  <= DEF_WIN;
        r_armed   <= 1'b0;
        r_applied <= 1'b0;
      end else begin
        r_applied <= w_apply;
        if (w_apply) begin
          r_active <= r_shadow;
          r_armed  <= 1'b0;
        end
        if (w_s1_wr && w_hit) begin
          r_shadow <= r_s1_win;
        end
        if (w_s1_arm && w_hit) begin
          r_armed <= 1'b1;
        end
      end
    end

    assign o_act_win[i*WIN_W +: WIN_W] = r_active;
    assign o_applied[i]                = r_applied;
  end

  assign o_cfg_ready = w_cfg_ready;
  assign o_cfg_err   = r_cfg_err;
  assign o_init_done = r_init_done;

endmodule
